menu_cursor_ctrl: RTL and testbench

- Cursor and selection controller for the VGA item menu.
- Converts button presses into the grid pointer (SW1pointer, 12 cells in a 3×4 grid) and the list pointer (SW2pointer, 6 name slots) that drive the menu indicator/highlight logic.
- Maintains a 6-entry cart of chosen item codes.
- Pointer outputs update only at frame start, so the highlight boxes never tear mid-frame.

---
 rtl/menu_cursor_ctrl_if.sv | 34 +++
 rtl/menu_cursor_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_menu_cursor_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/menu_cursor_ctrl_if.sv
// Menu cursor controller bus: button/frame inputs and cursor/cart outputs.
//   master : the button/video front end (drives buttons, reads pointers and cart)
//   slave  : menu_cursor_ctrl
interface menu_cursor_ctrl_if;
  logic        frame_start;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_sel;
  logic        btn_back;
  logic [11:0] possibleItems;
  logic [3:0]  SW1pointer;
  logic [3:0]  SW2pointer;
  logic        list_mode;
  logic [2:0]  cart_count;
  logic [23:0] cart_items;
  logic        cart_full;
  logic        evt_reject;

  modport master (
    output frame_start, btn_up, btn_down, btn_left, btn_right, btn_sel, btn_back,
           possibleItems,
    input  SW1pointer, SW2pointer, list_mode, cart_count, cart_items, cart_full,
           evt_reject
  );

  modport slave (
    input  frame_start, btn_up, btn_down, btn_left, btn_right, btn_sel, btn_back,
           possibleItems,
    output SW1pointer, SW2pointer, list_mode, cart_count, cart_items, cart_full,
           evt_reject
  );
endinterface

// File: rtl/menu_cursor_ctrl.sv
// Cursor and selection controller for the VGA item menu.
// Turns button presses into a 3x4 grid cursor and a 6-slot list cursor, keeps
// a 6-entry cart of item codes, and latches the displayed pointers at frame start.
// Ports:
//   clk   : pixel clock
//   rst_n : synchronous active-low reset
//   bus   : menu_cursor_ctrl_if.slave (buttons, frame_start, possibleItems in;
//           SW1pointer, SW2pointer, list_mode, cart_*, evt_reject out)
//
// state | meaning
// GRID  | cursor moves over the 12-item grid; sel adds cur1 to the cart
// LIST  | cursor moves over cart entries; sel removes the entry under cur2
module menu_cursor_ctrl #(
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter int CNT_W        = 24
) (
  input  logic                clk,
  input  logic                rst_n,
  menu_cursor_ctrl_if.slave   bus
);

  typedef enum logic {GRID = 1'b0, LIST = 1'b1} state_t;

  localparam logic [2:0] A_UP    = 3'd0;
  localparam logic [2:0] A_DOWN  = 3'd1;
  localparam logic [2:0] A_LEFT  = 3'd2;
  localparam logic [2:0] A_RIGHT = 3'd3;
  localparam logic [2:0] A_SEL   = 3'd4;
  localparam logic [2:0] A_BACK  = 3'd5;

  state_t           state_q, state_d;
  logic [3:0]       cur1_q, cur1_d, cur2_q, cur2_d;
  logic [23:0]      cart_q, cart_d;
  logic [2:0]       count_q, count_d;
  logic             reject_q, reject_d;
  logic [5:0]       btn_prev_q;
  logic             rep_on_q, rep_on_d;
  logic [1:0]       rep_dir_q, rep_dir_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [3:0]       sw1_q, sw2_q;
  logic             mode_q;

  logic [5:0]       btn, rise;
  logic [3:0]       dir_btn;
  logic             act_vld;
  logic [2:0]       act;
  logic [3:0]       col, last;
  logic [2:0]       new_cnt;
  logic [15:0]      possible;
  logic [27:0]      cart_ext;

  always_comb begin
    btn      = {bus.btn_back, bus.btn_sel, bus.btn_right, bus.btn_left,
                bus.btn_down, bus.btn_up};
    rise     = btn & ~btn_prev_q;
    dir_btn  = btn[3:0];
    possible = {4'd0, bus.possibleItems};
    cart_ext = {4'd0, cart_q};
    col      = cur1_q % 4'd3;
    last     = {1'b0, count_q} - 4'd1;
    new_cnt  = count_q - 3'd1;

    // lowest index wins, giving up > down > left > right > sel > back
    act_vld = 1'b0;
    act     = A_UP;
    for (int i = 5; i >= 0; i--) begin
      if (rise[i]) begin
        act_vld = 1'b1;
        act     = 3'(i);
      end
    end

    rep_on_d  = rep_on_q;
    rep_dir_d = rep_dir_q;
    rep_cnt_d = rep_cnt_q;
    if (act_vld) begin
      if (act <= A_RIGHT) begin
        rep_on_d  = 1'b1;
        rep_dir_d = act[1:0];
        rep_cnt_d = CNT_W'(1);
      end else begin
        rep_on_d  = 1'b0;
        rep_cnt_d = '0;
      end
    end else if (rep_on_q && dir_btn[rep_dir_q]) begin
      if (rep_cnt_q == CNT_W'(REPEAT_DELAY)) begin
        act_vld   = 1'b1;
        act       = {1'b0, rep_dir_q};
        // reload so the next compare against REPEAT_DELAY lands REPEAT_RATE later
        rep_cnt_d = CNT_W'(REPEAT_DELAY - REPEAT_RATE + 1);
      end else begin
        rep_cnt_d = rep_cnt_q + CNT_W'(1);
      end
    end else begin
      rep_on_d  = 1'b0;
      rep_cnt_d = '0;
    end

    state_d  = state_q;
    cur1_d   = cur1_q;
    cur2_d   = cur2_q;
    cart_d   = cart_q;
    count_d  = count_q;
    reject_d = 1'b0;

    if (act_vld) begin
      case (state_q)
        GRID: begin
          case (act)
            A_UP:    cur1_d = (cur1_q < 4'd3) ? cur1_q + 4'd9 : cur1_q - 4'd3;
            A_DOWN:  cur1_d = (cur1_q > 4'd8) ? cur1_q - 4'd9 : cur1_q + 4'd3;
            A_LEFT:  cur1_d = (col == 4'd0) ? cur1_q + 4'd2 : cur1_q - 4'd1;
            A_RIGHT: cur1_d = (col == 4'd2) ? cur1_q - 4'd2 : cur1_q + 4'd1;
            A_SEL: begin
              if (possible[cur1_q] && count_q < 3'd6) begin
                cart_d[{count_q, 2'b00} +: 4] = cur1_q;
                count_d = count_q + 3'd1;
              end else begin
                reject_d = 1'b1;
              end
            end
            A_BACK: begin
              if (count_q != 3'd0) begin
                state_d = LIST;
                cur2_d  = 4'd0;
              end else begin
                reject_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
        LIST: begin
          case (act)
            A_UP:   cur2_d = (cur2_q == 4'd0) ? last : cur2_q - 4'd1;
            A_DOWN: cur2_d = (cur2_q == last) ? 4'd0 : cur2_q + 4'd1;
            A_SEL: begin
              for (int k = 0; k < 6; k++) begin
                if (4'(k) >= cur2_q) cart_d[4*k +: 4] = cart_ext[4*k+4 +: 4];
              end
              count_d = new_cnt;
              if (new_cnt == 3'd0) begin
                state_d = GRID;
                cur2_d  = 4'd0;
              end else if (cur2_q == {1'b0, new_cnt}) begin
                cur2_d = {1'b0, new_cnt} - 4'd1;
              end
            end
            A_BACK: state_d = GRID;
            default: ;
          endcase
        end
        default: state_d = GRID;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= GRID;
      cur1_q     <= 4'd0;
      cur2_q     <= 4'd0;
      cart_q     <= 24'd0;
      count_q    <= 3'd0;
      reject_q   <= 1'b0;
      btn_prev_q <= 6'h3F;
      rep_on_q   <= 1'b0;
      rep_dir_q  <= 2'd0;
      rep_cnt_q  <= '0;
      sw1_q      <= 4'd0;
      sw2_q      <= 4'd0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur1_q     <= cur1_d;
      cur2_q     <= cur2_d;
      cart_q     <= cart_d;
      count_q    <= count_d;
      reject_q   <= reject_d;
      btn_prev_q <= btn;
      rep_on_q   <= rep_on_d;
      rep_dir_q  <= rep_dir_d;
      rep_cnt_q  <= rep_cnt_d;
      // current register values are the pre-action ones, so a same-cycle action is not shown
      if (bus.frame_start) begin
        sw1_q  <= cur1_q;
        sw2_q  <= cur2_q;
        mode_q <= (state_q == LIST);
      end
    end
  end

  assign bus.SW1pointer = sw1_q;
  assign bus.SW2pointer = sw2_q;
  assign bus.list_mode  = mode_q;
  assign bus.cart_count = count_q;
  assign bus.cart_items = cart_q;
  assign bus.cart_full  = (count_q == 3'd6);
  assign bus.evt_reject = reject_q;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
module tb_menu_cursor_ctrl;
  localparam int DLY  = 10;
  localparam int RATE = 4;
  localparam int UP = 0, DOWN = 1, LEFT = 2, RIGHT = 3, SEL = 4, BACK = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  menu_cursor_ctrl_if bus ();

  menu_cursor_ctrl #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .CNT_W(24)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        rej_seen;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_val(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    string t;
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %0d, nothing expected", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      UP:      bus.btn_up    = v;
      DOWN:    bus.btn_down  = v;
      LEFT:    bus.btn_left  = v;
      RIGHT:   bus.btn_right = v;
      SEL:     bus.btn_sel   = v;
      default: bus.btn_back  = v;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    tick();
    rej_seen = bus.evt_reject;
    set_btn(idx, 1'b0);
    tick();
  endtask

  task automatic frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  initial begin
    bus.frame_start   = 1'b0;
    bus.btn_up        = 1'b0;
    bus.btn_down      = 1'b0;
    bus.btn_left      = 1'b0;
    bus.btn_right     = 1'b1;
    bus.btn_sel       = 1'b0;
    bus.btn_back      = 1'b0;
    bus.possibleItems = 12'hFFF;
    rej_seen          = 1'b0;

    // reset with btn_right held
    tick(3);
    expect_val("rst_sw1", 0);   check(bus.SW1pointer);
    expect_val("rst_sw2", 0);   check(bus.SW2pointer);
    expect_val("rst_mode", 0);  check(bus.list_mode);
    expect_val("rst_count", 0); check(bus.cart_count);
    expect_val("rst_items", 0); check(bus.cart_items);
    expect_val("rst_full", 0);  check(bus.cart_full);
    expect_val("rst_rej", 0);   check(bus.evt_reject);
    rst_n = 1'b1;
    tick(3);
    expect_val("held_right_no_move", 0); frame(); check(bus.SW1pointer);
    bus.btn_right = 1'b0;
    tick();
    expect_val("right_after_release", 1); press(RIGHT); frame(); check(bus.SW1pointer);

    // grid wrap moves
    expect_val("left_to_0", 0); press(LEFT); frame(); check(bus.SW1pointer);
    press(LEFT);
    expect_val("left_wrap_not_latched", 0); check(bus.SW1pointer);
    expect_val("left_wrap_2", 2); frame(); check(bus.SW1pointer);
    expect_val("up_wrap_11", 11); press(UP); frame(); check(bus.SW1pointer);
    expect_val("down_wrap_2", 2); press(DOWN); frame(); check(bus.SW1pointer);

    // auto-repeat: steps at press, +DLY, +DLY+RATE, +DLY+2*RATE
    bus.btn_down = 1'b1;
    tick();
    tick(DLY - 1);
    bus.frame_start = 1'b1;
    expect_val("rep_before_first", 5); tick(); check(bus.SW1pointer);
    expect_val("rep_first", 8);        tick(); check(bus.SW1pointer);
    bus.frame_start = 1'b0;
    tick(RATE - 2);
    bus.frame_start = 1'b1;
    expect_val("rep_before_second", 8); tick(); check(bus.SW1pointer);
    expect_val("rep_second", 11);       tick(); check(bus.SW1pointer);
    bus.frame_start = 1'b0;
    tick(RATE - 2);
    bus.frame_start = 1'b1;
    expect_val("rep_before_wrap", 11); tick(); check(bus.SW1pointer);
    expect_val("rep_row_wrap", 2);     tick(); check(bus.SW1pointer);
    bus.frame_start = 1'b0;
    bus.btn_down = 1'b0;
    tick(2);

    // selection filter and full cart
    bus.possibleItems = 12'h005;
    press(LEFT);
    expect_val("sel_item1_rej", 1); press(SEL); check(rej_seen);
    expect_val("sel_item1_count", 0); check(bus.cart_count);
    press(LEFT);
    expect_val("sel_item0_ok", 0); press(SEL); check(rej_seen);
    press(LEFT);  press(SEL);
    press(RIGHT); press(SEL);
    press(LEFT);  press(SEL);
    press(RIGHT); press(SEL);
    press(LEFT);  press(SEL);
    expect_val("full_count", 6);        check(bus.cart_count);
    expect_val("full_flag", 1);         check(bus.cart_full);
    expect_val("full_items", 24'h202020); check(bus.cart_items);
    expect_val("sel7_rej", 1); press(SEL); check(rej_seen);
    expect_val("sel7_count", 6); check(bus.cart_count);

    // reset mid-session clears the cart
    rst_n = 1'b0;
    tick(2);
    expect_val("rst2_count", 0); check(bus.cart_count);
    expect_val("rst2_full", 0);  check(bus.cart_full);
    rst_n = 1'b1;
    bus.possibleItems = 12'hFFF;
    tick(2);

    // build cart [3,5,7]
    press(DOWN);  press(SEL);
    press(RIGHT); press(RIGHT); press(SEL);
    press(DOWN);  press(LEFT);  press(SEL);
    expect_val("cart_357", 24'h000753); check(bus.cart_items);
    expect_val("count_3", 3); check(bus.cart_count);

    // list navigation and removal
    press(BACK);
    frame();
    expect_val("list_mode_on", 1); check(bus.list_mode);
    expect_val("list_sw2_0", 0);   check(bus.SW2pointer);
    expect_val("list_up_wrap", 2); press(UP); frame(); check(bus.SW2pointer);
    press(DOWN);
    expect_val("list_down_wrap", 0); frame(); check(bus.SW2pointer);
    press(DOWN); press(DOWN);
    expect_val("list_left_no_rej", 0); press(LEFT); check(rej_seen);
    press(SEL);
    expect_val("remove_items", 24'h000053); check(bus.cart_items);
    expect_val("remove_count", 2); check(bus.cart_count);
    expect_val("remove_cur2", 1); frame(); check(bus.SW2pointer);
    press(SEL);
    press(SEL);
    expect_val("empty_count", 0); check(bus.cart_count);
    expect_val("empty_items", 0); check(bus.cart_items);
    frame();
    expect_val("empty_grid_mode", 0); check(bus.list_mode);
    expect_val("grid_cur1_kept", 7);  check(bus.SW1pointer);
    expect_val("back_empty_rej", 1); press(BACK); check(rej_seen);

    // up and sel rising together with frame_start
    bus.btn_up = 1'b1;
    bus.btn_sel = 1'b1;
    bus.frame_start = 1'b1;
    tick();
    expect_val("same_cycle_old_ptr", 7); check(bus.SW1pointer);
    expect_val("same_cycle_no_rej", 0);  check(bus.evt_reject);
    bus.btn_up = 1'b0;
    bus.btn_sel = 1'b0;
    bus.frame_start = 1'b0;
    tick();
    expect_val("same_cycle_no_sel", 0); check(bus.cart_count);
    expect_val("same_cycle_up", 4); frame(); check(bus.SW1pointer);

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d unchecked, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
